// File: rtl/factorial_pkg.sv
// Shared types and width helpers for the sequential factorial engine.
package factorial_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} fact_state_t;

  localparam int FACT_IN_W  = 4;
  localparam int FACT_OUT_W = 32;

  // The step counter carries one extra bit so k = 2**IN_W is representable.
  function automatic int k_width(input int in_w);
    return in_w + 1;
  endfunction

  function automatic int prod_width(input int in_w, input int out_w);
    return out_w + in_w + 1;
  endfunction

endpackage

// File: rtl/factorial_seq_engine_mul_step.sv
// One factorial step: acc*k truncated to OUT_W bits, plus a flag for lost upper bits.
module fact_mul_step
  import factorial_pkg::*;
#(
  parameter int IN_W  = FACT_IN_W,
  parameter int OUT_W = FACT_OUT_W
) (
  input  logic [OUT_W-1:0]          acc,
  input  logic [k_width(IN_W)-1:0]  k,
  output logic [OUT_W-1:0]          prod,
  output logic                      ovf_step
);

  localparam int P_W = prod_width(IN_W, OUT_W);

  logic [P_W-1:0] full;

  assign full     = P_W'(acc) * P_W'(k);
  assign prod     = full[OUT_W-1:0];
  assign ovf_step = |full[P_W-1:OUT_W];

endmodule

// File: rtl/factorial_seq_engine.sv
// Multi-cycle factorial unit: one multiply per clock, valid/ready on both sides.
module factorial_seq_engine
  import factorial_pkg::*;
#(
  parameter int IN_W  = FACT_IN_W,
  parameter int OUT_W = FACT_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             overflow,
  output logic             busy
);

  localparam int K_W = k_width(IN_W);

  fact_state_t      state_reg, state_next;
  logic [IN_W-1:0]  n_reg;
  logic [K_W-1:0]   k_reg;
  logic [OUT_W-1:0] acc_reg;
  logic             ovf_reg;
  logic [OUT_W-1:0] result_reg;
  logic             overflow_reg;

  logic [OUT_W-1:0] prod;
  logic             ovf_step;
  logic             calc_done;

  fact_mul_step #(.IN_W(IN_W), .OUT_W(OUT_W)) u_step (
    .acc      (acc_reg),
    .k        (k_reg),
    .prod     (prod),
    .ovf_step (ovf_step)
  );

  assign calc_done = (k_reg > {1'b0, n_reg});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (calc_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      n_reg        <= '0;
      k_reg        <= '0;
      acc_reg      <= '0;
      ovf_reg      <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            n_reg   <= n;
            acc_reg <= OUT_W'(1);
            k_reg   <= K_W'(2);
            ovf_reg <= 1'b0;
          end
        end
        CALC: begin
          if (calc_done) begin
            result_reg   <= acc_reg;
            overflow_reg <= ovf_reg;
          end else begin
            acc_reg <= prod;
            ovf_reg <= ovf_reg | ovf_step;
            k_reg   <= k_reg + K_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == CALC) || (state_reg == DONE);
  assign result    = result_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_factorial_seq_engine.sv
// Randomized self-checking bench for factorial_seq_engine against an arithmetic factorial model.
module tb_factorial_seq_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  n_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  factorial_seq_engine #(.IN_W(4), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // True n! in 64 bits (15! fits); the engine returns it mod 2**32.
  function automatic logic [63:0] ref_fact(input int nv);
    logic [63:0] p = 64'd1;
    for (int i = 2; i <= nv; i++) p = p * 64'(i);
    return p;
  endfunction

  task automatic run_job(input logic [3:0] nv, input int hold, input bit noise);
    logic [63:0] p;
    int lat;
    p = ref_fact(int'(nv));
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    n_in      = nv;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_in     = 4'($urandom);
    chk("busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, (nv == 0) ? 1 : nv);
    chk("result", result, p[31:0]);
    chk("overflow", overflow, (p >= 64'h1_0000_0000) ? 1 : 0);
    chk("in_ready_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        in_valid = 1'b1;
        n_in     = 4'd3;
      end
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, p[31:0]);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("busy_clear", busy, 0);
    chk("result_kept", result, p[31:0]);
    $display("job n=%0d lat=%0d result=%0d ovf=%0b hold=%0d", nv, lat, result, overflow, hold);
  endtask

  logic [3:0]  b2b_n   [3] = '{4'd2, 4'd3, 4'd4};
  logic [31:0] b2b_exp [3] = '{32'd2, 32'd6, 32'd24};

  initial begin
    int  next_i, got, cyc;
    bit  acc, hs, prev_hs;
    rst = 1'b1; in_valid = 1'b0; n_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);

    // Directed cases.
    run_job(4'd4, 0, 0);
    run_job(4'd5, 0, 0);
    run_job(4'd8, 0, 0);
    run_job(4'd0, 0, 0);
    run_job(4'd1, 0, 0);
    run_job(4'd12, 0, 0);
    run_job(4'd13, 0, 0);
    run_job(4'd15, 0, 0);
    run_job(4'd6, 10, 1);
    run_job(4'd3, 0, 0);

    // Reset in the middle of a job aborts it.
    in_valid = 1'b1; n_in = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_overflow", overflow, 0);
    $display("reset abort of n=10 job");
    run_job(4'd7, 0, 0);

    // Back-to-back stream with in_valid held high.
    in_valid = 1'b1; n_in = b2b_n[0]; out_ready = 1'b1;
    next_i = 1; got = 0; cyc = 0; prev_hs = 1'b0;
    while (got < 3 && cyc < 100) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (prev_hs) chk("b2b_idle_ready", in_ready, 1);
      if (hs) begin
        chk("b2b_result", result, b2b_exp[got]);
        $display("b2b job %0d result=%0d", got, result);
        got++;
      end
      prev_hs = hs;
      @(posedge clk); cyc++;
      #1;
      if (acc) begin
        if (next_i < 3) begin
          n_in = b2b_n[next_i];
          next_i++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", got, 3);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Random operands and consumer stalls.
    for (int j = 0; j < 25; j++)
      run_job(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
